// File: rtl/mtr_pwm_drv.sv
// mtr_pwm_drv: dual-channel complementary PWM motor driver.
// Converts per-wheel 11-bit speed and direction into forward/reverse gate enables.
// A shared 2048-cycle period counter is used. Duty and direction are latched only at
// period boundaries. Dead time is inserted on power-up and on every direction change.
// Optional feature: define SLEW_LIMIT_EN to limit each duty increase to SLEW_STEP per period.
module mtr_pwm_drv #(
    parameter int DEAD_CYC  = 32,
    parameter int SLEW_STEP = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwr_up,
    input  logic [10:0] lft_spd,
    input  logic        lft_rev,
    input  logic [10:0] rght_spd,
    input  logic        rght_rev,
    output logic        PWM_frwrd_lft,
    output logic        PWM_rev_lft,
    output logic        PWM_frwrd_rght,
    output logic        PWM_rev_rght,
    output logic        period_strb
);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        DEAD = 2'd1,
        RUN  = 2'd2
    } chan_state_e;

    localparam logic [9:0] DEAD_LOAD = 10'(DEAD_CYC);

`ifdef SLEW_LIMIT_EN
    localparam logic [11:0] SLEW_INC = 12'(SLEW_STEP);

    // Duty used when a channel starts from zero drive (power-up or reversal)
    function automatic logic [10:0] entryDuty(input logic [10:0] spd);
        if ({1'b0, spd} > SLEW_INC) begin
            return SLEW_INC[10:0];
        end
        return spd;
    endfunction

    // Increases are rate limited; decreases take effect at once
    function automatic logic [10:0] runDuty(input logic [10:0] spd, input logic [10:0] duty);
        logic [11:0] lim;
        lim = {1'b0, duty} + SLEW_INC;
        if (spd > duty && {1'b0, spd} > lim) begin
            return lim[10:0];
        end
        return spd;
    endfunction
`else
    logic [10:0] unusedSlew;
    assign unusedSlew = 11'(SLEW_STEP);
`endif

    logic [10:0] cnt_q;
    logic        strb_q;
    logic        boundary;

    logic [10:0] spdIn [2];
    logic        revIn [2];

    chan_state_e state_q [2];
    chan_state_e state_d [2];
    logic [10:0] duty_q  [2];
    logic [10:0] duty_d  [2];
    logic        dir_q   [2];
    logic        dir_d   [2];
    logic [9:0]  dead_q  [2];
    logic [9:0]  dead_d  [2];
    logic        frwrd_q [2];
    logic        frwrd_d [2];
    logic        rev_q   [2];
    logic        rev_d   [2];

    assign spdIn[0] = lft_spd;
    assign spdIn[1] = rght_spd;
    assign revIn[0] = lft_rev;
    assign revIn[1] = rght_rev;

    // The last cycle of a period is where new duty and direction take effect
    assign boundary = (cnt_q == 11'h7FF);

    // Free-running period counter and the strobe marking the first cycle of a period
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            strb_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_q + 11'd1;
            strb_q <= boundary;
        end
    end

    // Per-channel OFF/DEAD/RUN sequencing, latching, and the registered PWM compare
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            state_d[ch] = state_q[ch];
            duty_d[ch]  = duty_q[ch];
            dir_d[ch]   = dir_q[ch];
            dead_d[ch]  = dead_q[ch];

            case (state_q[ch])
                OFF: begin
                    if (boundary) begin
                        state_d[ch] = DEAD;
                        dead_d[ch]  = DEAD_LOAD;
                        dir_d[ch]   = revIn[ch];
`ifdef SLEW_LIMIT_EN
                        duty_d[ch]  = entryDuty(spdIn[ch]);
`else
                        duty_d[ch]  = spdIn[ch];
`endif
                    end
                end
                DEAD: begin
                    if (dead_q[ch] <= 10'd1) begin
                        state_d[ch] = RUN;
                        dead_d[ch]  = '0;
                    end else begin
                        dead_d[ch]  = dead_q[ch] - 10'd1;
                    end
                    if (boundary) begin
                        dir_d[ch]  = revIn[ch];
                        duty_d[ch] = spdIn[ch];
                    end
                end
                RUN: begin
                    if (boundary) begin
                        dir_d[ch] = revIn[ch];
                        if (revIn[ch] != dir_q[ch]) begin
                            state_d[ch] = DEAD;
                            dead_d[ch]  = DEAD_LOAD;
`ifdef SLEW_LIMIT_EN
                            duty_d[ch]  = entryDuty(spdIn[ch]);
`else
                            duty_d[ch]  = spdIn[ch];
`endif
                        end else begin
`ifdef SLEW_LIMIT_EN
                            duty_d[ch]  = runDuty(spdIn[ch], duty_q[ch]);
`else
                            duty_d[ch]  = spdIn[ch];
`endif
                        end
                    end
                end
                default: begin
                    state_d[ch] = OFF;
                end
            endcase

            if (!pwr_up) begin
                state_d[ch] = OFF;
                duty_d[ch]  = '0;
                dead_d[ch]  = '0;
            end

            frwrd_d[ch] = pwr_up && (state_q[ch] == RUN) && !dir_q[ch] && (cnt_q < duty_q[ch]);
            rev_d[ch]   = pwr_up && (state_q[ch] == RUN) &&  dir_q[ch] && (cnt_q < duty_q[ch]);
        end
    end

    // Channel state registers; reset leaves every leg undriven
    always_ff @(posedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (rst) begin
                state_q[ch] <= OFF;
                duty_q[ch]  <= '0;
                dir_q[ch]   <= 1'b0;
                dead_q[ch]  <= '0;
                frwrd_q[ch] <= 1'b0;
                rev_q[ch]   <= 1'b0;
            end else begin
                state_q[ch] <= state_d[ch];
                duty_q[ch]  <= duty_d[ch];
                dir_q[ch]   <= dir_d[ch];
                dead_q[ch]  <= dead_d[ch];
                frwrd_q[ch] <= frwrd_d[ch];
                rev_q[ch]   <= rev_d[ch];
            end
        end
    end

    assign PWM_frwrd_lft  = frwrd_q[0];
    assign PWM_rev_lft    = rev_q[0];
    assign PWM_frwrd_rght = frwrd_q[1];
    assign PWM_rev_rght   = rev_q[1];
    assign period_strb    = strb_q;

endmodule
